// File: rtl/pipe_reg_pkg.sv
// Shared helpers for the multi-port bubble-collapsing pipe register:
// level-width sizing and parameter legality.
package pipe_reg_pkg;

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit cfg_legal(input int depth, input int nports, input int cnt_w);
    return (depth >= 1) && (nports >= 1) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One slot of the collapsing chain: a valid flag plus its data word.
// A load takes priority over a departure; a departing slot with nothing arriving clears to zero.
module pipe_reg_stage
  import pipe_reg_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DSIZE-1:0] in_data,
  input  logic             go,
  output logic             valid,
  output logic [DSIZE-1:0] data
);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
    end else if (go) begin
      valid <= 1'b0;
      data  <= '0;
    end
  end

endmodule

// File: rtl/pipe_reg_nwrite_ports.sv
// DEPTH-stage bubble-collapsing register chain fed by NPORTS fixed-priority write ports.
// Optional saturating drop counter output enabled by defining PIPE_REG_DROP_CNT_EN.
module pipe_reg_nwrite_ports
  import pipe_reg_pkg::*;
#(
  parameter int DSIZE  = 8,
  parameter int NPORTS = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic [NPORTS-1:0]         wr_en,
  input  logic [NPORTS*DSIZE-1:0]   indata,
  input  logic                      low_empty,
  output logic [NPORTS-1:0]         wr_ack,
  output logic                      wr_drop,
  output logic                      valid,
  output logic                      curr_empty,
  output logic                      sum_empty,
  output logic [DSIZE-1:0]          outdata,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      full
`ifdef PIPE_REG_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0]          drop_cnt
`endif
);

  localparam int LW = lvl_w(DEPTH);

  if (!cfg_legal(DEPTH, NPORTS, CNT_W)) begin : g_bad_cfg
    $error("pipe_reg_nwrite_ports: DEPTH, NPORTS and CNT_W must all be >= 1");
  end

  logic [DEPTH-1:0] stg_vld;
  logic [DEPTH-1:0] stg_go;
  logic [DSIZE-1:0] stg_data [DEPTH];
  logic [DSIZE-1:0] win_data;
  logic             accept;
  logic             wr_acc;
  logic             out_go;

  // Advance chain: a stage moves when the next one is empty or itself moving,
  // resolved tail to head so a full chain can shift as a whole in one cycle.
  always_comb begin
    logic [DEPTH-1:0] g;
    g = '0;
    g[DEPTH-1] = stg_vld[DEPTH-1] & low_empty;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      g[k] = stg_vld[k] & (~stg_vld[k+1] | g[k+1]);
    end
    stg_go = g;
  end

  assign out_go = stg_go[DEPTH-1];

  // Fixed-priority write select: lowest asserted port wins stage 0
  always_comb begin
    logic found;
    found    = 1'b0;
    wr_ack   = '0;
    win_data = '0;
    accept   = ~stg_vld[0] | stg_go[0];
    if (rst_n && accept) begin
      for (int p = 0; p < NPORTS; p++) begin
        if (wr_en[p] && !found) begin
          found     = 1'b1;
          wr_ack[p] = 1'b1;
          win_data  = indata[p*DSIZE +: DSIZE];
        end
      end
    end
    wr_acc  = found;
    wr_drop = rst_n & (|(wr_en & ~wr_ack));
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             ld;
    logic [DSIZE-1:0] ld_data;
    if (k == 0) begin : g_head
      assign ld      = wr_acc;
      assign ld_data = win_data;
    end else begin : g_body
      assign ld      = stg_go[k-1];
      assign ld_data = stg_data[k-1];
    end

    pipe_reg_stage #(
      .DSIZE(DSIZE)
    ) u_stage (
      .clock  (clock),
      .rst_n  (rst_n),
      .load   (ld),
      .in_data(ld_data),
      .go     (stg_go[k]),
      .valid  (stg_vld[k]),
      .data   (stg_data[k])
    );
  end

  // Occupancy tracking
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      level <= '0;
    end else if (wr_acc && !out_go) begin
      level <= level + 1'b1;
    end else if (!wr_acc && out_go) begin
      level <= level - 1'b1;
    end
  end

  assign full       = (level == LW'(DEPTH));
  assign valid      = stg_vld[DEPTH-1];
  assign outdata    = valid ? stg_data[DEPTH-1] : '0;
  assign curr_empty = ~valid;
  assign sum_empty  = curr_empty | low_empty;

`ifdef PIPE_REG_DROP_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // One count per dropping cycle, regardless of how many ports lost
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (wr_drop) begin
      drop_cnt <= sat_inc(drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_nwrite_ports.sv
// Randomized self-checking bench for pipe_reg_nwrite_ports against a slot-array reference model.
// Exercises drop_cnt too when PIPE_REG_DROP_CNT_EN is defined.
module tb_pipe_reg_nwrite_ports;

  localparam int DSIZE  = 8;
  localparam int NPORTS = 2;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;
  localparam int LW     = $clog2(DEPTH + 1);
  localparam int IW     = NPORTS * DSIZE;

  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic [NPORTS-1:0] wr_en = '0;
  logic [IW-1:0]     indata = '0;
  logic              low_empty = 1'b0;
  logic [NPORTS-1:0] wr_ack;
  logic              wr_drop;
  logic              valid;
  logic              curr_empty;
  logic              sum_empty;
  logic [DSIZE-1:0]  outdata;
  logic [LW-1:0]     level;
  logic              full;
`ifdef PIPE_REG_DROP_CNT_EN
  logic [CNT_W-1:0]  drop_cnt;
`endif

  always #5 clock = ~clock;

  pipe_reg_nwrite_ports #(
    .DSIZE (DSIZE),
    .NPORTS(NPORTS),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .indata    (indata),
    .low_empty (low_empty),
    .wr_ack    (wr_ack),
    .wr_drop   (wr_drop),
    .valid     (valid),
    .curr_empty(curr_empty),
    .sum_empty (sum_empty),
    .outdata   (outdata),
    .level     (level),
    .full      (full)
`ifdef PIPE_REG_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference: which chain slots hold a word, and which word
  bit               m_v [DEPTH];
  logic [DSIZE-1:0] m_d [DEPTH];
  int               m_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic rn, input logic [NPORTS-1:0] we,
                      input logic [IW-1:0] din, input logic le);
    bit               nv [DEPTH];
    logic [DSIZE-1:0] nd [DEPTH];
    logic [NPORTS-1:0] eack;
    logic             edrop;
    int               occ;
    @(negedge clock);
    rst_n     = rn;
    wr_en     = we;
    indata    = din;
    low_empty = le;
    #1;
    nv = m_v;
    nd = m_d;
    if (nv[DEPTH-1] && le) begin
      nv[DEPTH-1] = 1'b0;
      nd[DEPTH-1] = '0;
    end
    for (int k = DEPTH - 2; k >= 0; k--) begin
      if (nv[k] && !nv[k+1]) begin
        nv[k+1] = 1'b1;
        nd[k+1] = nd[k];
        nv[k]   = 1'b0;
        nd[k]   = '0;
      end
    end
    eack = '0;
    if (rn && !nv[0]) begin
      for (int p = 0; p < NPORTS; p++) begin
        if (we[p]) begin
          eack[p] = 1'b1;
          nv[0]   = 1'b1;
          nd[0]   = din[p*DSIZE +: DSIZE];
          break;
        end
      end
    end
    edrop = rn && ((we & ~eack) != '0);
    check_val("wr_ack", 32'(wr_ack), 32'(eack));
    check_val("wr_drop", 32'(wr_drop), 32'(edrop));
    @(posedge clock);
    if (!rn) begin
      for (int k = 0; k < DEPTH; k++) begin
        m_v[k] = 1'b0;
        m_d[k] = '0;
      end
      m_cnt = 0;
    end else begin
      m_v = nv;
      m_d = nd;
      if (edrop && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
    #1;
    occ = 0;
    for (int k = 0; k < DEPTH; k++) occ += int'(m_v[k]);
    check_val("valid", 32'(valid), 32'(m_v[DEPTH-1]));
    check_val("outdata", 32'(outdata), m_v[DEPTH-1] ? 32'(m_d[DEPTH-1]) : 32'(0));
    check_val("level", 32'(level), 32'(occ));
    check_val("full", 32'(full), 32'(occ == DEPTH));
    check_val("curr_empty", 32'(curr_empty), 32'(!m_v[DEPTH-1]));
    check_val("sum_empty", 32'(sum_empty), 32'(!m_v[DEPTH-1] || le));
`ifdef PIPE_REG_DROP_CNT_EN
    check_val("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
`endif
  endtask

  initial begin
    logic              rn;
    logic [NPORTS-1:0] we;
    logic [IW-1:0]     rd;
    logic              le;
    for (int k = 0; k < DEPTH; k++) begin
      m_v[k] = 1'b0;
      m_d[k] = '0;
    end

    // Writes requested while in reset must be ignored
    repeat (2) step(1'b0, 2'b11, IW'($urandom), 1'b1);

    // Single word via port 1, held downstream, then released
    step(1'b1, 2'b10, 16'hA500, 1'b0);
    repeat (5) step(1'b1, 2'b00, 16'h0000, 1'b0);
    step(1'b1, 2'b00, 16'h0000, 1'b1);
    step(1'b1, 2'b00, 16'h0000, 1'b0);

    // Both ports at once: port 0 wins
    step(1'b1, 2'b11, 16'h2211, 1'b1);
    repeat (5) step(1'b1, 2'b00, 16'h0000, 1'b1);

    // Fill with output blocked, then overflow
    for (int i = 1; i <= 6; i++) step(1'b1, 2'b01, 16'(i), 1'b0);

    // Full chain streaming at one word per cycle
    for (int i = 7; i <= 20; i++) step(1'b1, 2'b01, 16'(i), 1'b1);
    repeat (6) step(1'b1, 2'b00, 16'h0000, 1'b1);

    // Long overflow run saturates the drop counter
    repeat (300) step(1'b1, 2'b01, IW'($urandom), 1'b0);
`ifdef PIPE_REG_DROP_CNT_EN
    check_val("drop_sat", 32'(drop_cnt), 32'hFF);
`endif

    // Release one word, then reset with three held
    step(1'b1, 2'b00, 16'h0000, 1'b1);
    step(1'b0, 2'b01, 16'h00EE, 1'b0);
    step(1'b1, 2'b00, 16'h0000, 1'b0);

    // Random traffic with varying downstream availability
    for (int ph = 0; ph < 5; ph++) begin
      repeat (600) begin
        rn = ($urandom_range(0, 199) != 0);
        we = NPORTS'($urandom);
        rd = IW'($urandom);
        le = ($urandom_range(0, 3) < ph);
        step(rn, we, rd, le);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
